// File: rtl/debounce_bank.sv
// debounce_bank
// Multi-channel switch debouncer with synchroniser, stability filter,
// press/release pulses and per-channel auto-repeat for held keys.
//
// Parameters:
//   CHANNELS      number of independent channels (>=1)
//   SYNC_STAGES   synchroniser flops per channel (>=2)
//   STABLE_CYCLES consecutive disagreeing samples needed to change level (>=2)
//   INVERT        1 = raw inputs are active-low
//   REPEAT_DELAY  cycles from press edge to first repeat pulse (>=1)
//   REPEAT_RATE   cycles between later repeat pulses (>=1)
//
// Ports:
//   clk            rising-edge clock
//   rst_n          synchronous active-low reset
//   raw_in         asynchronous switch inputs
//   repeat_en      per-channel auto-repeat enable
//   level          debounced level (1 = pressed/closed)
//   press          one-cycle pulse on level 0->1
//   release_pulse  one-cycle pulse on level 1->0 ("release" is a reserved word)
//   repeat_pulse   one-cycle auto-repeat pulses ("repeat" is a reserved word)
//   held           auto-repeat FSM state per channel (1 = HELD), for observation
//
// Every output is a flop; there is no combinational input-to-output path.
module debounce_bank #(
  parameter int CHANNELS      = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 16,
  parameter int INVERT        = 0,
  parameter int REPEAT_DELAY  = 1000,
  parameter int REPEAT_RATE   = 250
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] raw_in,
  input  logic [CHANNELS-1:0] repeat_en,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] press,
  output logic [CHANNELS-1:0] release_pulse,
  output logic [CHANNELS-1:0] repeat_pulse,
  output logic [CHANNELS-1:0] held
);

  localparam int CNT_W  = $clog2(STABLE_CYCLES);
  localparam int RC_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RC_W   = $clog2(RC_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RC_W-1:0]  RC_DELAY = RC_W'(REPEAT_DELAY);
  localparam logic [RC_W-1:0]  RC_RATE  = RC_W'(REPEAT_RATE);
  localparam logic             INV_BIT  = (INVERT != 0);

  typedef enum logic {
    RPT_IDLE = 1'b0,
    RPT_HELD = 1'b1
  } rpt_state_t;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync;
    logic                   sync_out;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_inc;
    logic                   lvl_q;
    logic                   press_q;
    logic                   rel_q;
    logic                   flip;
    logic                   rise;
    logic                   fall;
    rpt_state_t             state;
    logic [RC_W-1:0]        rc;
    logic [RC_W-1:0]        rc_inc;
    logic [RC_W-1:0]        thr;
    logic                   first_done;
    logic                   rpt_q;

    assign sync_out = sync[SYNC_STAGES-1];
    assign cnt_inc  = cnt + CNT_W'(1);
    assign rc_inc   = rc + RC_W'(1);

    // The level changes on this edge: the filter has counted a full run.
    assign flip = (sync_out != lvl_q) && (cnt == CNT_LAST);
    assign rise = flip && sync_out;
    assign fall = flip && !sync_out;

    // Until the first repeat after a press (or a re-enable) the longer
    // delay applies; afterwards the repeat rate.
    assign thr = first_done ? RC_RATE : RC_DELAY;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        sync <= '0;
      end else begin
        sync <= {sync[SYNC_STAGES-2:0], raw_in[c] ^ INV_BIT};
      end
    end

    // Stability filter: any sample agreeing with the current level restarts
    // the count, so only an unbroken run of STABLE_CYCLES samples flips it.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        cnt     <= '0;
        lvl_q   <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
      end else begin
        press_q <= rise;
        rel_q   <= fall;
        if (sync_out == lvl_q) begin
          cnt <= '0;
        end else if (flip) begin
          lvl_q <= sync_out;
          cnt   <= '0;
        end else begin
          cnt <= cnt_inc;
        end
      end
    end

    // Auto-repeat FSM. HELD coincides with level=1; the release edge leaves
    // HELD without a pulse even if the counter would have hit its threshold.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state      <= RPT_IDLE;
        rc         <= '0;
        first_done <= 1'b0;
        rpt_q      <= 1'b0;
      end else begin
        rpt_q <= 1'b0;
        case (state)
          RPT_IDLE: begin
            if (rise) begin
              state      <= RPT_HELD;
              rc         <= '0;
              first_done <= 1'b0;
            end
          end
          RPT_HELD: begin
            if (fall) begin
              state      <= RPT_IDLE;
              rc         <= '0;
              first_done <= 1'b0;
            end else if (!repeat_en[c]) begin
              rc         <= '0;
              first_done <= 1'b0;
            end else if (rc_inc == thr) begin
              rpt_q      <= 1'b1;
              rc         <= '0;
              first_done <= 1'b1;
            end else begin
              rc <= rc_inc;
            end
          end
          default: begin
            state <= RPT_IDLE;
          end
        endcase
      end
    end

    assign level[c]         = lvl_q;
    assign press[c]         = press_q;
    assign release_pulse[c] = rel_q;
    assign repeat_pulse[c]  = rpt_q;
    assign held[c]          = (state == RPT_HELD);
  end

endmodule

// File: tb/tb_debounce_bank.sv
// tb_debounce_bank
// Drives two debounce_bank instances (normal and inverted inputs, shared
// clock, reset and repeat_en) and checks them cycle by cycle against a
// timestamp-based reference model, plus explicit timing checks per scenario.
module tb_debounce_bank;

  localparam int CH = 4;
  localparam int SS = 2;
  localparam int SC = 4;
  localparam int RD = 10;
  localparam int RR = 3;
  localparam int NE = 64;

  logic          clk;
  logic          rst_n;
  logic [CH-1:0] raw0, raw1, en;
  logic [CH-1:0] level0, press0, rel0, rpt0, held0;
  logic [CH-1:0] level1, press1, rel1, rpt1, held1;
  logic [19:0]   obs0, obs1;

  assign obs0 = {held0, rpt0, rel0, press0, level0};
  assign obs1 = {held1, rpt1, rel1, press1, level1};

  int n_vec = 0;
  int n_err = 0;

  debounce_bank #(
    .CHANNELS(CH), .SYNC_STAGES(SS), .STABLE_CYCLES(SC), .INVERT(0),
    .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .raw_in(raw0), .repeat_en(en),
    .level(level0), .press(press0), .release_pulse(rel0),
    .repeat_pulse(rpt0), .held(held0)
  );

  debounce_bank #(
    .CHANNELS(CH), .SYNC_STAGES(SS), .STABLE_CYCLES(SC), .INVERT(1),
    .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut_inv (
    .clk(clk), .rst_n(rst_n), .raw_in(raw1), .repeat_en(en),
    .level(level1), .press(press1), .release_pulse(rel1),
    .repeat_pulse(rpt1), .held(held1)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  // Conditioned samples are stored by edge number. The filter decision at
  // edge n uses the sample taken SS edges earlier; the level flips when the
  // last SC such samples all disagree with it. Samples taken at or before
  // the last reset edge read as 0 (flushed synchroniser).
  bit          samp [2][CH][NE];
  int          edge_no   = 0;
  int          rst_edge  = 0;
  logic [CH-1:0] m_level[2], m_press[2], m_rel[2], m_rpt[2];
  int          anchor    [2][CH];
  bit          use_delay [2][CH];
  bit          ms, mchg, mv, mwas;
  logic [39:0] exp_q[$];

  always @(posedge clk) begin
    edge_no++;
    if (!rst_n) begin
      rst_edge = edge_no;
      for (int k = 0; k < 2; k++) begin
        m_level[k] = '0; m_press[k] = '0; m_rel[k] = '0; m_rpt[k] = '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        for (int c = 0; c < CH; c++) begin
          ms = (k == 0) ? raw0[c] : ~raw1[c];
          samp[k][c][edge_no % NE] = ms;
          mchg = 1'b1;
          for (int w = edge_no - SS - SC + 1; w <= edge_no - SS; w++) begin
            mv = 1'b0;
            if (w > rst_edge) mv = samp[k][c][w % NE];
            if (mv == m_level[k][c]) mchg = 1'b0;
          end
          mwas = m_level[k][c];
          m_press[k][c] = mchg && !mwas;
          m_rel[k][c]   = mchg && mwas;
          m_rpt[k][c]   = 1'b0;
          if (mchg) m_level[k][c] = ~mwas;
          if (m_press[k][c]) begin
            anchor[k][c]    = edge_no;
            use_delay[k][c] = 1'b1;
          end else if (mwas && !mchg) begin
            if (!en[c]) begin
              anchor[k][c]    = edge_no;
              use_delay[k][c] = 1'b1;
            end else if (edge_no - anchor[k][c] == (use_delay[k][c] ? RD : RR)) begin
              m_rpt[k][c]     = 1'b1;
              anchor[k][c]    = edge_no;
              use_delay[k][c] = 1'b0;
            end
          end
        end
      end
    end
    exp_q.push_back({m_level[1], m_rpt[1], m_rel[1], m_press[1], m_level[1],
                     m_level[0], m_rpt[0], m_rel[0], m_press[0], m_level[0]});
  end

  // Advance one edge and fetch the model's expectation for it.
  task automatic next_cycle(output logic [19:0] e0, output logic [19:0] e1);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      e0 = 'x;
      e1 = 'x;
    end else begin
      {e1, e0} = exp_q.pop_front();
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [19:0] e0, e1;
    rst_n = 1'b0; raw0 = 4'hF; raw1 = 4'h0; en = 4'h0;
    for (int i = 0; i < 3; i++) begin
      next_cycle(e0, e1);
      n_vec++;
      if (obs0 !== 20'h0) begin n_err++; $display("FAIL reset_hold dut0 cycle %0d: got %h want %h", i, obs0, 20'h0); end
      n_vec++;
      if (obs1 !== 20'h0) begin n_err++; $display("FAIL reset_hold dut1 cycle %0d: got %h want %h", i, obs1, 20'h0); end
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      next_cycle(e0, e1);
      n_vec++;
      if (obs0 !== e0) begin n_err++; $display("FAIL reset_model dut0 edge %0d: got %h want %h", k, obs0, e0); end
      n_vec++;
      if (obs1 !== e1) begin n_err++; $display("FAIL reset_model dut1 edge %0d: got %h want %h", k, obs1, e1); end
      n_vec++;
      if (level0 !== ((k >= 6) ? 4'hF : 4'h0)) begin n_err++; $display("FAIL reset_level edge %0d: got %h want %h", k, level0, (k >= 6) ? 4'hF : 4'h0); end
      n_vec++;
      if (press0 !== ((k == 6) ? 4'hF : 4'h0)) begin n_err++; $display("FAIL reset_press edge %0d: got %h want %h", k, press0, (k == 6) ? 4'hF : 4'h0); end
    end
  endtask

  task automatic test_bounce();
    logic [19:0] e0, e1;
    int presses = 0;
    int rise_at = -1;
    raw0 = 4'h0; raw1 = 4'hF;
    for (int i = 0; i < 10; i++) begin
      next_cycle(e0, e1);
      n_vec++;
      if (obs0 !== e0) begin n_err++; $display("FAIL bounce_settle dut0 cycle %0d: got %h want %h", i, obs0, e0); end
      n_vec++;
      if (obs1 !== e1) begin n_err++; $display("FAIL bounce_settle dut1 cycle %0d: got %h want %h", i, obs1, e1); end
    end
    for (int i = 0; i < 14; i++) begin
      raw0[0] = (i < 4) ? ((i % 2) == 0) : 1'b1;
      next_cycle(e0, e1);
      n_vec++;
      if (obs0 !== e0) begin n_err++; $display("FAIL bounce_model dut0 cycle %0d: got %h want %h", i, obs0, e0); end
      if (press0[0] === 1'b1) presses++;
      if (level0[0] === 1'b1 && rise_at < 0) rise_at = i - 3;
    end
    n_vec++;
    if (presses != 1) begin n_err++; $display("FAIL bounce_press_count: got %0d want 1", presses); end
    n_vec++;
    if (rise_at != 6) begin n_err++; $display("FAIL bounce_latency: got edge %0d want edge 6", rise_at); end
  endtask

  task automatic test_auto_repeat();
    logic [19:0] e0, e1;
    logic exp_r;
    int t = -1;
    int rel_at = -1;
    int d;
    en[1] = 1'b1;
    raw0[1] = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      next_cycle(e0, e1);
      n_vec++;
      if (obs0 !== e0) begin n_err++; $display("FAIL repeat_model dut0 cycle %0d: got %h want %h", i, obs0, e0); end
      if (t < 0 && press0[1] === 1'b1) t = i;
      if (t >= 0) begin
        d = i - t;
        exp_r = (d >= 10) && (d <= 25) && (((d - 10) % 3) == 0);
        n_vec++;
        if (rpt0[1] !== exp_r) begin n_err++; $display("FAIL repeat_pulse T+%0d: got %b want %b", d, rpt0[1], exp_r); end
        if (rel0[1] === 1'b1 && rel_at < 0) rel_at = d;
        if (d == 20) raw0[1] = 1'b0;
      end
    end
    n_vec++;
    if (t != 6) begin n_err++; $display("FAIL repeat_press_latency: got edge %0d want edge 6", t); end
    n_vec++;
    if (rel_at != 26) begin n_err++; $display("FAIL repeat_release_edge: got T+%0d want T+26", rel_at); end
  endtask

  task automatic test_en_drop();
    logic [19:0] e0, e1;
    logic exp_r;
    int t = -1;
    int d;
    en[2] = 1'b1;
    raw0[2] = 1'b1;
    for (int i = 1; i <= 70; i++) begin
      next_cycle(e0, e1);
      n_vec++;
      if (obs0 !== e0) begin n_err++; $display("FAIL en_drop_model dut0 cycle %0d: got %h want %h", i, obs0, e0); end
      if (t < 0 && press0[2] === 1'b1) t = i;
      if (t >= 0) begin
        d = i - t;
        exp_r = (d >= 30) && (d <= 42) && (((d - 30) % 3) == 0);
        n_vec++;
        if (rpt0[2] !== exp_r) begin n_err++; $display("FAIL en_drop_pulse T+%0d: got %b want %b", d, rpt0[2], exp_r); end
        if (d == 5)  en[2] = 1'b0;
        if (d == 20) en[2] = 1'b1;
        if (d == 37) raw0[2] = 1'b0;
      end
    end
    n_vec++;
    if (t != 6) begin n_err++; $display("FAIL en_drop_press_latency: got edge %0d want edge 6", t); end
  endtask

  task automatic test_invert();
    logic [19:0] e0, e1;
    raw0 = 4'h0; raw1 = 4'hF;
    for (int i = 0; i < 8; i++) begin
      next_cycle(e0, e1);
      n_vec++;
      if (obs1 !== e1) begin n_err++; $display("FAIL invert_settle dut1 cycle %0d: got %h want %h", i, obs1, e1); end
    end
    raw1[3] = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      if ((i % 3) == 1) begin
        raw0[2:0] = 3'($urandom_range(0, 7));
        raw1[2:0] = 3'($urandom_range(0, 7));
      end
      next_cycle(e0, e1);
      n_vec++;
      if (obs0 !== e0) begin n_err++; $display("FAIL invert_model dut0 cycle %0d: got %h want %h", i, obs0, e0); end
      n_vec++;
      if (obs1 !== e1) begin n_err++; $display("FAIL invert_model dut1 cycle %0d: got %h want %h", i, obs1, e1); end
      n_vec++;
      if (level1[3] !== (i >= 6)) begin n_err++; $display("FAIL invert_level3 dut1 edge %0d: got %b want %b", i, level1[3], (i >= 6)); end
      n_vec++;
      if (level0[3] !== 1'b0) begin n_err++; $display("FAIL invert_level3 dut0 edge %0d: got %b want 0", i, level0[3]); end
    end
  endtask

  task automatic test_random();
    logic [19:0] e0, e1;
    for (int i = 0; i < 800; i++) begin
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 15) == 0) raw0[c] = ~raw0[c];
        if ($urandom_range(0, 15) == 0) raw1[c] = ~raw1[c];
      end
      if ($urandom_range(0, 31) == 0) en = 4'($urandom_range(0, 15));
      next_cycle(e0, e1);
      n_vec++;
      if (obs0 !== e0) begin n_err++; $display("FAIL random_model dut0 cycle %0d: got %h want %h", i, obs0, e0); end
      n_vec++;
      if (obs1 !== e1) begin n_err++; $display("FAIL random_model dut1 cycle %0d: got %h want %h", i, obs1, e1); end
    end
  endtask

  task automatic test_reset_mid_hold();
    logic [19:0] e0, e1;
    bit seen = 1'b0;
    raw0 = 4'h0; raw1 = 4'hF; en = 4'b0010;
    for (int i = 0; i < 8; i++) begin
      next_cycle(e0, e1);
      n_vec++;
      if (obs0 !== e0) begin n_err++; $display("FAIL midrst_settle dut0 cycle %0d: got %h want %h", i, obs0, e0); end
    end
    raw0[1] = 1'b1;
    for (int i = 1; i <= 40 && !seen; i++) begin
      next_cycle(e0, e1);
      n_vec++;
      if (obs0 !== e0) begin n_err++; $display("FAIL midrst_hold dut0 cycle %0d: got %h want %h", i, obs0, e0); end
      if (rpt0[1] === 1'b1) seen = 1'b1;
    end
    n_vec++;
    if (!seen) begin n_err++; $display("FAIL midrst_no_repeat: got none want a repeat pulse within 40 cycles"); end
    rst_n = 1'b0;
    next_cycle(e0, e1);
    n_vec++;
    if (level0 !== 4'h0) begin n_err++; $display("FAIL midrst_level: got %h want 0", level0); end
    n_vec++;
    if (rpt0 !== 4'h0) begin n_err++; $display("FAIL midrst_repeat: got %h want 0", rpt0); end
    n_vec++;
    if (rel0 !== 4'h0) begin n_err++; $display("FAIL midrst_release: got %h want 0", rel0); end
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      next_cycle(e0, e1);
      n_vec++;
      if (obs0 !== e0) begin n_err++; $display("FAIL midrst_model dut0 edge %0d: got %h want %h", k, obs0, e0); end
      n_vec++;
      if (press0 !== ((k == 6) ? 4'b0010 : 4'b0000)) begin n_err++; $display("FAIL midrst_repress edge %0d: got %h want %h", k, press0, (k == 6) ? 4'b0010 : 4'b0000); end
      n_vec++;
      if (rel0 !== 4'h0) begin n_err++; $display("FAIL midrst_no_release edge %0d: got %h want 0", k, rel0); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst_n = 1'b0; raw0 = 4'h0; raw1 = 4'h0; en = 4'h0;
    test_reset();
    test_bounce();
    test_auto_repeat();
    test_en_drop();
    test_invert();
    test_random();
    test_reset_mid_hold();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/debounce_bank.md
# debounce_bank

Parametrised multi-channel debouncer for the front-panel keypad and door switch inputs. It synchronises each raw asynchronous input and filters it with a per-channel stability counter. For each channel it produces:
- a clean level;
- one-cycle press and release pulses;
- an optional auto-repeat pulse train for held keys, used for time entry.

It sits between the pad inputs and the control FSM. It replaces single-channel, fixed-length debouncing.

## Interface
Parameters:
- CHANNELS, 4: number of independent input channels (≥1).
- SYNC_STAGES, 2: synchroniser flops per channel (≥2).
- STABLE_CYCLES, 16: consecutive agreeing samples required to change level (≥2).
- INVERT, 0: 1 = raw inputs are active-low and are inverted before the synchroniser.
- REPEAT_DELAY, 1000: cycles from press to first repeat pulse (≥1).
- REPEAT_RATE, 250: cycles between subsequent repeat pulses (≥1).

Ports:
- clk  in  1  rising-edge clock for all state.
- rst_n  in  1  synchronous, active-low reset.
- raw_in  in  CHANNELS  asynchronous switch inputs.
- repeat_en  in  CHANNELS  per-channel auto-repeat enable.
- level  out  CHANNELS  debounced, registered state (1 = pressed/closed).
- press  out  CHANNELS  one-cycle pulse on a level 0→1 change.
- release  out  CHANNELS  one-cycle pulse on a level 1→0 change.
- repeat  out  CHANNELS  one-cycle auto-repeat pulses while held.

## Operation
- Channels are fully independent; all per-channel logic is replicated by a generate loop.
- Input conditioning: s = raw_in XOR INVERT, then passed through a SYNC_STAGES flop chain. sync_out is the last stage.
- Stability counter cnt, width $clog2(STABLE_CYCLES). On each edge:
  - sync_out == level: cnt ← 0.
  - sync_out != level and cnt < STABLE_CYCLES-1: cnt ← cnt+1.
  - sync_out != level and cnt == STABLE_CYCLES-1: level ← sync_out, cnt ← 0.
- Glitch rule: any single sample agreeing with level during a count clears cnt. The count restarts from zero.
- Pulses: press/release are registered and asserted on the same edge that level changes. Each is high for exactly one cycle.
- Auto-repeat runs per channel as a 2-state FSM, IDLE / HELD, with counter rc of width $clog2(max(REPEAT_DELAY,REPEAT_RATE)+1).
  - IDLE → HELD on the press edge, with rc ← 0. No repeat pulse on the press edge itself.
  - HELD, level=1, repeat_en=1:
    - rc ← rc+1.
    - When rc+1 == REPEAT_DELAY (first pulse) or == REPEAT_RATE (later pulses): repeat ← 1 and rc ← 0.
    - An internal "first" flag selects which of the two thresholds applies.
  - HELD, repeat_en=0: rc and the first flag are held cleared and repeat stays 0. Re-enabling restarts the REPEAT_DELAY wait.
  - HELD → IDLE on the release edge. repeat is 0 on that edge; rc and the first flag are cleared.
- press and repeat are never asserted in the same cycle on one channel.

## Timing
- Reset (rst_n=0 at an edge): all sync flops, cnt, level, press, release, repeat ← 0, FSM ← IDLE. Reset overrides everything.
- Reset asserted mid-count or mid-hold discards state with no pulse emitted. After reset, a held input is re-detected as a fresh press after full latency.
- Press latency: count the first edge that samples the new raw value as edge 1. level/press change on edge SYNC_STAGES+STABLE_CYCLES (defaults: edge 18). Release latency is the same.
- Inputs shorter than STABLE_CYCLES synchronised samples never change level.
- First repeat: REPEAT_DELAY edges after the press edge. Later repeats: every REPEAT_RATE edges.
- Repeat counters saturate only by wrap-to-zero at the threshold. There is no overflow path.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
Bench uses CHANNELS=4, SYNC_STAGES=2, STABLE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3.
- Reset: hold rst_n=0 for 3 cycles with raw_in=4'hF → all outputs 0. Release reset → level=4'hF and press=4'hF (one cycle) on edge 6 after release.
- Bounce: ch0 raw toggles 1,0,1 with a 2-cycle period, then holds 1 → no press until 4 clean synchronised samples. Exactly one press pulse; level[0]=1 on edge 6 from the start of the stable period.
- Auto-repeat: hold ch1 with repeat_en[1]=1 → press at T, repeat at T+10, T+13, T+16. Release → release pulse; no repeat after the release edge.
- repeat_en drop: hold ch2 and drop repeat_en[2] at T+5 → no repeat pulses. Raise it again at T+20 → first repeat at T+30.
- Independence and INVERT: run a second instance with INVERT=1. Drive raw_in[3]=0 while ch0–2 toggle → only level[3] responds on the inverted sense; the other channel timings are unaffected.
- Reset mid-hold: assert rst_n=0 while ch1 is repeating → repeat/level go 0 on the next edge, with no release pulse.
